// File: rtl/in_fifo_tx.sv
// IN endpoint transmit FIFO: application bytes are buffered in a circular store
// and handed to the SIE one packet at a time, kept until the host ACKs them.
module in_fifo_tx #(
   parameter int IN_MAXPACKETSIZE = 8,
   parameter int BIT_SAMPLES      = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] app_in_data_i,
   input  logic       app_in_valid_i,
   output logic       app_in_ready_o,
   output logic       in_empty_o,
   output logic       in_full_o,
   input  logic       in_req_i,
   output logic       in_nak_o,
   output logic [7:0] in_data_o,
   output logic       in_valid_o,
   input  logic       in_ready_i,
   input  logic       in_ack_i
);

   localparam int IN_LENGTH = IN_MAXPACKETSIZE + 1;
   localparam int PTR_W     = $clog2(IN_LENGTH);
   localparam int CNT_W     = $clog2(IN_MAXPACKETSIZE + 1);
   localparam int DLY_W     = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;

   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(IN_LENGTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IN_MAXPACKETSIZE);
   localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(BIT_SAMPLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_WAIT_ACK
   } state_t;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   logic [7:0]       mem_q [IN_LENGTH];
   state_t           state_q;
   logic [PTR_W-1:0] first_q, rd_q, last_q, last_d;
   logic [CNT_W-1:0] cnt_q;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic             nak_q;
   logic             done_q;
   logic             wr_en;

   // One slot is always left unused so that full and empty stay distinguishable.
   assign in_empty_o     = (first_q == last_q);
   assign in_full_o      = (ptr_inc(last_q) == first_q);
   assign app_in_ready_o = (dly_q == DLY_MAX) && !in_full_o;
   assign wr_en          = app_in_valid_i && app_in_ready_o;

   // done_q latches the end of the packet so late writes cannot revive in_valid_o.
   assign in_valid_o = (state_q == ST_DATA) && !done_q &&
                       (rd_q != last_q) && (cnt_q < CNT_MAX);
   assign in_data_o  = mem_q[rd_q];
   assign in_nak_o   = nak_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      last_d = last_q;
      dly_d  = dly_q;
      if (wr_en) begin
         last_d = ptr_inc(last_q);
         dly_d  = '0;
      end else if (dly_q != DLY_MAX) begin
         dly_d = dly_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= '0;
         dly_q  <= '0;
      end else begin
         last_q <= last_d;
         dly_q  <= dly_d;
      end
   end

   // NOTE: the byte store is not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[last_q] <= app_in_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         first_q <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         nak_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         nak_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (in_req_i) begin
                  if (in_empty_o) begin
                     nak_q <= 1'b1;
                  end else begin
                     rd_q    <= first_q;
                     cnt_q   <= '0;
                     done_q  <= 1'b0;
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (!in_valid_o) begin
                  done_q <= 1'b1;
               end
               if (in_ready_i) begin
                  if (in_valid_o) begin
                     rd_q  <= ptr_inc(rd_q);
                     cnt_q <= cnt_q + 1'b1;
                  end else begin
                     state_q <= ST_WAIT_ACK;
                  end
               end
            end
            ST_WAIT_ACK: begin
               if (in_ack_i) begin
                  first_q <= rd_q;
                  state_q <= ST_IDLE;
               end else if (in_req_i) begin
                  rd_q    <= first_q;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  state_q <= ST_DATA;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_in_fifo_tx.sv
// Directed bench for in_fifo_tx: expected IN bytes are queued as stimulus is
// issued, and a negedge monitor compares every byte the SIE consumes.
module tb_in_fifo_tx;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] app_in_data_i;
   logic       app_in_valid_i;
   logic       app_in_ready_o;
   logic       in_empty_o;
   logic       in_full_o;
   logic       in_req_i;
   logic       in_nak_o;
   logic [7:0] in_data_o;
   logic       in_valid_o;
   logic       in_ready_i;
   logic       in_ack_i;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q [$];

   in_fifo_tx #(.IN_MAXPACKETSIZE(8), .BIT_SAMPLES(4)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .app_in_data_i  (app_in_data_i),
      .app_in_valid_i (app_in_valid_i),
      .app_in_ready_o (app_in_ready_o),
      .in_empty_o     (in_empty_o),
      .in_full_o      (in_full_o),
      .in_req_i       (in_req_i),
      .in_nak_o       (in_nak_o),
      .in_data_o      (in_data_o),
      .in_valid_o     (in_valid_o),
      .in_ready_i     (in_ready_i),
      .in_ack_i       (in_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      app_in_data_i  = b;
      app_in_valid_i = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (app_in_ready_o) break;
         tick();
      end
      check("write_ready", app_in_ready_o, 1);
      tick();
      app_in_valid_i = 1'b0;
   endtask

   task automatic pulse_req();
      in_req_i = 1'b1;
      tick();
      in_req_i = 1'b0;
   endtask

   task automatic pulse_ready();
      in_ready_i = 1'b1;
      tick();
      in_ready_i = 1'b0;
   endtask

   task automatic pulse_ack();
      in_ack_i = 1'b1;
      tick();
      in_ack_i = 1'b0;
   endtask

   // Token, n data handshakes, then the terminating handshake with in_valid_o low.
   task automatic send_packet(input int n);
      pulse_req();
      check("valid_start", in_valid_o, 1);
      repeat (n) pulse_ready();
      check("valid_end", in_valid_o, 0);
      pulse_ready();
   endtask

   always @(negedge clk_i) begin
      if (!rst_i && in_valid_o && in_ready_i) begin
         if (exp_q.size() == 0) check("unexpected_byte", {24'h0, in_data_o}, 32'hFFFF_FFFF);
         else                   check("in_data", {24'h0, in_data_o}, {24'h0, exp_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int accepts;
      int last_cyc;

      rst_i = 1'b1;
      app_in_data_i = 8'h00;
      app_in_valid_i = 1'b0;
      in_req_i = 1'b0;
      in_ready_i = 1'b0;
      in_ack_i = 1'b0;
      tick();
      tick();
      check("rst_empty", in_empty_o, 1);
      check("rst_full", in_full_o, 0);
      check("rst_valid", in_valid_o, 0);
      check("rst_nak", in_nak_o, 0);
      check("rst_app_ready", app_in_ready_o, 0);
      rst_i = 1'b0;
      tick();

      // Token on an empty buffer: one-cycle NAK, nothing valid.
      pulse_req();
      check("empty_nak", in_nak_o, 1);
      check("empty_valid", in_valid_o, 0);
      tick();
      check("empty_nak_clear", in_nak_o, 0);

      // Throttle: ready once every BIT_SAMPLES cycles until full.
      accepts = 0;
      last_cyc = 0;
      app_in_valid_i = 1'b1;
      for (int cyc = 0; cyc < 200 && accepts < 8; cyc++) begin
         app_in_data_i = 8'(accepts + 1);
         if (app_in_ready_o) begin
            if (accepts > 0) check("throttle_gap", cyc - last_cyc, 4);
            last_cyc = cyc;
            accepts++;
         end
         tick();
      end
      check("throttle_accepts", accepts, 8);
      check("full_set", in_full_o, 1);
      check("full_app_ready", app_in_ready_o, 0);
      app_in_valid_i = 1'b0;
      for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
      send_packet(8);
      pulse_ack();
      check("drain_empty", in_empty_o, 1);
      check("drain_full", in_full_o, 0);

      // Send and acknowledge three bytes.
      for (int i = 0; i < 3; i++) write_byte(8'hA0 + 8'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(8'hA0 + 8'(i));
      send_packet(3);
      check("ack_wait_empty", in_empty_o, 0);
      pulse_ack();
      check("ack_empty", in_empty_o, 1);

      // Retransmit on a repeated token without an ACK.
      for (int i = 0; i < 3; i++) write_byte(8'hA0 + 8'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(8'hA0 + 8'(i));
      send_packet(3);
      for (int i = 0; i < 3; i++) exp_q.push_back(8'hA0 + 8'(i));
      send_packet(3);
      check("retx_not_empty", in_empty_o, 0);
      pulse_ack();
      check("retx_empty", in_empty_o, 1);

      // A byte written after the packet starts joins it while valid is still high.
      write_byte(8'hB0);
      exp_q.push_back(8'hB0);
      exp_q.push_back(8'hB1);
      pulse_req();
      write_byte(8'hB1);
      check("join_valid", in_valid_o, 1);
      pulse_ready();
      pulse_ready();
      check("join_valid_end", in_valid_o, 0);
      pulse_ready();
      pulse_ack();
      check("join_empty", in_empty_o, 1);

      // Twelve bytes across two acked packets, wrapping the pointers.
      for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
      check("wrap_full", in_full_o, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
      send_packet(8);
      pulse_ack();
      for (int i = 8; i < 12; i++) write_byte(8'h10 + 8'(i));
      for (int i = 8; i < 12; i++) exp_q.push_back(8'h10 + 8'(i));
      send_packet(4);
      pulse_ack();
      check("wrap_empty", in_empty_o, 1);

      // Reset in the middle of a packet discards everything.
      write_byte(8'hC0);
      write_byte(8'hC1);
      exp_q.push_back(8'hC0);
      pulse_req();
      pulse_ready();
      rst_i = 1'b1;
      tick();
      check("midrst_valid", in_valid_o, 0);
      check("midrst_empty", in_empty_o, 1);
      rst_i = 1'b0;
      tick();
      pulse_req();
      check("midrst_nak", in_nak_o, 1);
      tick();
      check("midrst_nak_clear", in_nak_o, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
